// File: rtl/mem_bus_pkg.sv
// Shared types and constants for the data memory responder: FSM states,
// default geometry and the widths used by the address error check.
package mem_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam int DEF_DEPTH = 256;
    localparam int DEF_WAIT  = 2;

    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int ALIGN_W = 2;
    localparam int CNT_W   = 3;

    // A word request is bad if it is not word aligned or indexes past the array.
    function automatic logic addr_err(input logic [ADDR_W-1:0] addr,
                                      input int unsigned       depth);
        logic [ADDR_W-1:0] idx;
        idx = {{ALIGN_W{1'b0}}, addr[ADDR_W-1:ALIGN_W]};
        return (addr[ALIGN_W-1:0] != '0) || (idx >= depth);
    endfunction

endpackage

// File: rtl/dm_word_array.sv
// Word storage: synchronous write, registered read and a one-cycle
// synchronous clear of every word and of the read register.
module dm_word_array
    import mem_bus_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              we,
    input  logic              re,
    input  logic              rclr,
    input  logic [AW-1:0]     addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            rdata <= '0;
        end else begin
            if (we) begin
                mem[addr] <= wdata;
            end
            // The read register doubles as the response data, so it is
            // zeroed when the response is consumed.
            if (re) begin
                rdata <= mem[addr];
            end else if (rclr) begin
                rdata <= '0;
            end
        end
    end

endmodule

// File: rtl/data_mem_responder.sv
// Single-outstanding load/store responder with a fixed number of wait
// states, alignment/range checking and a handshaked response.
module data_mem_responder
    import mem_bus_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int WAIT  = DEF_WAIT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = (WAIT > 0) ? CNT_W'(WAIT - 1) : '0;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic              lat_write;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic              ready_q;
    logic              valid_q;
    logic              err_q;

    logic              accept;
    logic              enter_resp;
    logic              complete;
    logic              src_write;
    logic [ADDR_W-1:0] src_addr;
    logic [DATA_W-1:0] src_wdata;
    logic              src_err;
    logic              arr_we;
    logic              arr_re;
    logic [AW-1:0]     arr_addr;
    logic [DATA_W-1:0] arr_rdata;

    // With no wait states the array is accessed on the acceptance edge itself,
    // before the latch holds the request, so the live inputs are used there.
    always_comb begin
        accept     = req_valid && (state == ST_IDLE);
        complete   = (state == ST_RESP) && rsp_ready;
        if (WAIT == 0) begin
            enter_resp = accept;
        end else begin
            enter_resp = (state == ST_BUSY) && (cnt == '0);
        end
        if (state == ST_IDLE) begin
            src_write = req_write;
            src_addr  = req_addr;
            src_wdata = req_wdata;
        end else begin
            src_write = lat_write;
            src_addr  = lat_addr;
            src_wdata = lat_wdata;
        end
        src_err  = addr_err(src_addr, DEPTH);
        arr_we   = rst && enter_resp && src_write && !src_err;
        arr_re   = rst && enter_resp && !src_write && !src_err;
        arr_addr = src_addr[AW+ALIGN_W-1:ALIGN_W];
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            lat_write <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            ready_q   <= 1'b1;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        lat_write <= req_write;
                        lat_addr  <= req_addr;
                        lat_wdata <= req_wdata;
                        ready_q   <= 1'b0;
                        if (WAIT == 0) begin
                            state   <= ST_RESP;
                            valid_q <= 1'b1;
                            err_q   <= src_err;
                        end else begin
                            state <= ST_BUSY;
                            cnt   <= CNT_INIT;
                        end
                    end
                end
                ST_BUSY: begin
                    if (cnt == '0) begin
                        state   <= ST_RESP;
                        valid_q <= 1'b1;
                        err_q   <= src_err;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_RESP: begin
                    if (complete) begin
                        state   <= ST_IDLE;
                        valid_q <= 1'b0;
                        ready_q <= 1'b1;
                        err_q   <= 1'b0;
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    ready_q <= 1'b1;
                    valid_q <= 1'b0;
                    err_q   <= 1'b0;
                end
            endcase
        end
    end

    dm_word_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .clk   (clk),
        .clr   (!rst),
        .we    (arr_we),
        .re    (arr_re),
        .rclr  (complete),
        .addr  (arr_addr),
        .wdata (src_wdata),
        .rdata (arr_rdata)
    );

    assign req_ready = ready_q;
    assign rsp_valid = valid_q;
    assign rsp_err   = err_q;
    assign rsp_rdata = arr_rdata;

endmodule
